fifo_stream_port: RTL and testbench

- Client-side end of the fifoConnect interface: drives the reader modport of a fifo core.
- Upstream: a valid/ready input stream, converted to link.write/link.datain.
- Downstream: pops the core and presents a fully registered valid/ready output stream through a 2-entry output buffer.
- Lets stream-style blocks attach to any fifo core without touching write/read timing rules. m_ready never reaches link.read combinationally.

---
 rtl/fifo_stream_port_if.sv | 28 ++
 rtl/fifo_stream_port.sv | 121 ++++++++++++
 tb/tb_fifo_stream_port.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_port_if.sv
// fifoConnect link between a fifo core and its client. The core is show-ahead and
// publishes registered fill status/level; the reader side drives write/read/datain.
interface fifo_stream_port_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
);
  typedef struct packed {
    logic full;
    logic empty;
  } fill_status_t;

  logic [WIDTH-1:0]           datain;
  logic [WIDTH-1:0]           dataout;
  logic                       write;
  logic                       read;
  fill_status_t               fillStatus;
  logic [$clog2(DEPTH+1)-1:0] fillLevel;

  modport reader (
    output datain, write, read,
    input  dataout, fillStatus, fillLevel
  );

  modport core (
    input  datain, write, read,
    output dataout, fillStatus, fillLevel
  );
endinterface

// File: rtl/fifo_stream_port.sv
// Stream adapter for the reader end of a fifo core: valid/ready in to core writes,
// core pops out through a 2-entry registered buffer to a valid/ready output.
module fifo_stream_port #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 32,
  parameter int CNTBITS = 32,
  localparam int LW     = $clog2(DEPTH+1) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  fifo_stream_port_if.reader   link,
  output logic [LW-1:0]        level,
  output logic [CNTBITS-1:0]   in_count,
  output logic [CNTBITS-1:0]   out_count
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]         occ_q, occ_d;
  logic [WIDTH-1:0]   slot0_q, slot0_d;
  logic [WIDTH-1:0]   slot1_q, slot1_d;
  logic               m_valid_q;
  logic [CNTBITS-1:0] in_count_q, out_count_q;
  logic               pop;
  logic               take;

  // Core handshake: read looks only at registered state so m_ready never reaches it.
  always_comb begin
    s_ready     = !link.fillStatus.full;
    link.datain = s_data;
    if (reset) begin
      link.write = s_valid && !link.fillStatus.full;
      link.read  = !link.fillStatus.empty && (occ_q < ST_TWO);
    end else begin
      link.write = 1'b0;
      link.read  = 1'b0;
    end
  end

  assign pop  = link.read;
  assign take = m_valid_q && m_ready;

  // Output buffer next state: slot0 is the presented head, slot1 the skid entry.
  always_comb begin
    occ_d   = occ_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    case (occ_q)
      ST_EMPTY: begin
        if (pop) begin
          occ_d   = ST_ONE;
          slot0_d = link.dataout;
        end else begin
          occ_d   = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (pop && take) begin
          slot0_d = link.dataout;
        end else if (pop) begin
          occ_d   = ST_TWO;
          slot1_d = link.dataout;
        end else if (take) begin
          occ_d   = ST_EMPTY;
        end else begin
          occ_d   = ST_ONE;
        end
      end
      ST_TWO: begin
        if (take) begin
          occ_d   = ST_ONE;
          slot0_d = slot1_q;
        end else begin
          occ_d   = ST_TWO;
        end
      end
      default: begin
        occ_d = ST_EMPTY;
      end
    endcase
  end

  // Buffer, registered valid and transfer counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q       <= ST_EMPTY;
      slot0_q     <= {WIDTH{1'b0}};
      slot1_q     <= {WIDTH{1'b0}};
      m_valid_q   <= 1'b0;
      in_count_q  <= {CNTBITS{1'b0}};
      out_count_q <= {CNTBITS{1'b0}};
    end else begin
      occ_q     <= occ_d;
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
      m_valid_q <= (occ_d != ST_EMPTY);
      if (link.write) begin
        in_count_q <= in_count_q + CNTBITS'(1'b1);
      end
      if (take) begin
        out_count_q <= out_count_q + CNTBITS'(1'b1);
      end
    end
  end

  assign m_data    = slot0_q;
  assign m_valid   = m_valid_q;
  assign in_count  = in_count_q;
  assign out_count = out_count_q;
  // Sum of registered terms; LW leaves one spare bit so DEPTH+2 cannot overflow.
  assign level     = LW'(link.fillLevel) + LW'(occ_q);

endmodule

// File: tb/tb_fifo_stream_port.sv
// Bench for fifo_stream_port: behavioural show-ahead core, scoreboard of accepted
// words, and a negedge monitor comparing the output stream, level and counters.
module tb_fifo_stream_port;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int CNTBITS = 4;
  localparam int LW      = $clog2(DEPTH+1) + 1;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [WIDTH-1:0]   s_data = 8'h00;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [WIDTH-1:0]   m_data;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic [LW-1:0]      level;
  logic [CNTBITS-1:0] in_count;
  logic [CNTBITS-1:0] out_count;

  fifo_stream_port_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) link ();

  fifo_stream_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTBITS(CNTBITS)) dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .link(link),
    .level(level), .in_count(in_count), .out_count(out_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pops = 0;
  int acc = 0;
  int delivered = 0;
  int lost = 0;
  int acc_base = 0;
  int deliv_base = 0;
  int first_valid_cyc = -1;
  int outst;
  logic [WIDTH-1:0] sb[$];
  int dcyc[$];
  logic [WIDTH-1:0] exp_word;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Behavioural show-ahead core: plain ring buffer with registered count.
  logic [WIDTH-1:0] cmem [DEPTH];
  logic [1:0] c_wp = 2'd0;
  logic [1:0] c_rp = 2'd0;
  logic [2:0] c_cnt = 3'd0;

  assign link.dataout    = cmem[c_rp];
  assign link.fillStatus = {c_cnt == 3'd4, c_cnt == 3'd0};
  assign link.fillLevel  = c_cnt;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (link.write) begin
      chk("no_write_when_full", longint'(c_cnt != 3'd4), 64'd1);
      chk("datain_is_s_data", longint'(link.datain), longint'(s_data));
      cmem[c_wp] <= link.datain;
      c_wp <= c_wp + 2'd1;
    end
    if (link.read) begin
      chk("no_read_when_empty", longint'(c_cnt != 3'd0), 64'd1);
      c_rp <= c_rp + 2'd1;
      pops <= pops + 1;
    end
    c_cnt <= c_cnt + {2'b00, link.write} - {2'b00, link.read};
    if (s_valid && reset && c_cnt != 3'd4) begin
      sb.push_back(s_data);
      acc <= acc + 1;
    end
  end

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    outst = pops - delivered - lost;
    chk("write_rule", longint'(link.write), longint'(s_valid && reset && c_cnt != 3'd4));
    chk("level", longint'(level), longint'(c_cnt) + outst);
    if (link.read) chk("no_read_with_two_buffered", longint'(outst < 2), 64'd1);
    if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (m_valid && m_ready) begin
      if (sb.size() == 0) begin
        chk("scoreboard_underflow", 64'd0, 64'd1);
      end else begin
        exp_word = sb.pop_front();
        chk("m_data", longint'(m_data), longint'(exp_word));
      end
      delivered++;
      dcyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    int a0;
    int n;
    a0 = acc;
    n = 0;
    s_valid = 1'b1;
    s_data = d;
    while (acc == a0 && n < 30) begin
      tick();
      n++;
    end
    if (acc == a0) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    while ((sb.size() != 0 || c_cnt != 3'd0) && n < 80) begin
      tick();
      n++;
    end
    if (n >= 80) chk("drain_timeout", 64'd0, 64'd1);
    tick();
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_in_count"}, longint'(in_count), longint'((acc - acc_base) % 16));
    chk({tag, "_out_count"}, longint'(out_count), longint'((delivered - deliv_base) % 16));
  endtask

  initial begin
    int c0;
    s_valid = 1'b1;
    s_data = 8'h5A;
    tick(); tick();
    chk("rst_m_valid", longint'(m_valid), 64'd0);
    chk("rst_m_data", longint'(m_data), 64'd0);
    chk("rst_in_count", longint'(in_count), 64'd0);
    chk("rst_out_count", longint'(out_count), 64'd0);
    chk("rst_write", longint'(link.write), 64'd0);
    chk("rst_read", longint'(link.read), 64'd0);
    s_valid = 1'b0;
    reset = 1'b1;
    tick();

    // Back-to-back writes with the sink ready: latency and no bubble.
    m_ready = 1'b1;
    first_valid_cyc = -1;
    dcyc.delete();
    c0 = cyc;
    send(8'h11); send(8'h22); send(8'h33);
    s_valid = 1'b0;
    drain();
    @(negedge clk);
    chk("first_latency", longint'(first_valid_cyc - c0), 64'd2);
    chk("t1_deliveries", longint'(dcyc.size()), 64'd3);
    if (dcyc.size() == 3) chk("t1_consecutive", longint'(dcyc[2] - dcyc[0]), 64'd2);
    chk("t1_in_count", longint'(in_count), 64'd3);
    chk("t1_out_count", longint'(out_count), 64'd3);

    // Stalled sink: fill core plus buffer.
    tick();
    m_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send(8'(i));
    s_data = 8'h07;
    tick(); tick(); tick();
    @(negedge clk);
    chk("full_s_ready", longint'(s_ready), 64'd0);
    chk("full_no_write", longint'(link.write), 64'd0);
    chk("full_level", longint'(level), 64'd6);
    chk("full_m_valid", longint'(m_valid), 64'd1);
    chk("full_head", longint'(m_data), 64'd1);
    tick();
    s_valid = 1'b0;

    // Release the sink: six words, one per cycle.
    dcyc.delete();
    drain();
    @(negedge clk);
    chk("t3_deliveries", longint'(dcyc.size()), 64'd6);
    if (dcyc.size() == 6) chk("t3_no_bubble", longint'(dcyc[5] - dcyc[0]), 64'd5);
    chk("t3_level", longint'(level), 64'd0);
    chk("t3_m_valid", longint'(m_valid), 64'd0);
    check_counters("t3");

    // Toggling then random sink readiness with random writes.
    tick();
    for (int i = 0; i < 300; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data = 8'($urandom);
      m_ready = (i < 40) ? (i % 2 == 0) : ($urandom_range(0, 2) != 0);
      tick();
    end
    drain();
    @(negedge clk);
    check_counters("t4");

    // Asynchronous reset with two words buffered.
    tick();
    m_ready = 1'b0;
    send(8'hA1); send(8'hA2); send(8'hA3);
    s_valid = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    chk("t5_m_valid_before", longint'(m_valid), 64'd1);
    @(posedge clk);
    #3;
    s_valid = 1'b1;
    s_data = 8'hEE;
    reset = 1'b0;
    outst = pops - delivered - lost;
    for (int i = 0; i < outst; i++) if (sb.size() != 0) void'(sb.pop_front());
    lost = lost + outst;
    #1;
    chk("t5_async_m_valid", longint'(m_valid), 64'd0);
    chk("t5_async_in_count", longint'(in_count), 64'd0);
    chk("t5_async_out_count", longint'(out_count), 64'd0);
    chk("t5_read_low", longint'(link.read), 64'd0);
    chk("t5_write_low", longint'(link.write), 64'd0);
    chk("t5_level", longint'(level), longint'(c_cnt));
    acc_base = acc;
    deliv_base = delivered;
    tick(); tick();
    s_valid = 1'b0;
    reset = 1'b1;
    drain();
    @(negedge clk);
    chk("t5_in_after", longint'(in_count), 64'd0);
    chk("t5_out_after", longint'(out_count), 64'd1);

    // Counter wrap: 20 words through 4-bit counters.
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    acc_base = acc;
    deliv_base = delivered;
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(8'(8'h40 + i));
    s_valid = 1'b0;
    drain();
    @(negedge clk);
    chk("wrap_in_count", longint'(in_count), 64'd4);
    chk("wrap_out_count", longint'(out_count), 64'd4);
    chk("wrap_scoreboard_empty", longint'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
